img_loader_144: RTL and testbench
=================================

# img_loader_144

Upstream feeder for the 144-64-10 TCB network top. Accepts an image as a byte-serial pixel stream with valid/ready handshake and packs 144 pixels into the flat 144×8 image bus. Issues a one-cycle start pulse to the network's `valid_top`, holds the image stable until the network's `ready_top`, then captures the predicted class from `number` before accepting the next frame.

## Interface
- `N_PIX`, default 144: pixels per image.
- `PIX_W`, default 8: bits per pixel.
- `clk`  in  1: system clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `pix_in`  in  PIX_W: incoming pixel byte.
- `pix_valid`  in  1: `pix_in` valid this cycle.
- `pix_sof`  in  1: qualifies `pix_valid`; this pixel is pixel 0 of a new frame.
- `pix_ready`  out  1: loader accepts a pixel this cycle.
- `img_source`  out  N_PIX*PIX_W: packed image to the network; pixel k at bits [k*PIX_W +: PIX_W].
- `valid_top`  out  1: one-cycle start pulse to the network.
- `ready_top`  in  1: network done pulse; `number` valid in the same cycle.
- `number`  in  32: network prediction.
- `result`  out  32: last captured prediction.
- `result_valid`  out  1: one-cycle pulse when `result` updates.
- `frame_cnt`  out  16: count of completed frames; wraps 0xFFFF→0.

## Operation
- States: FILL, LAUNCH, WAIT.
- FILL:
  - `pix_ready`=1. A pixel is accepted when `pix_valid`&`pix_ready`.
  - An accepted pixel is written to slot `idx`, 8-bit `idx` = 0..N_PIX-1; `idx` then increments.
  - An accepted pixel with `pix_sof`=1 is written to slot 0 and `idx` becomes 1. The partial frame is discarded: old slots are not cleared but will be overwritten.
  - Accepting slot N_PIX-1 (including an sof pixel when N_PIX=1) → `idx`←0, next state LAUNCH.
- LAUNCH:
  - `pix_ready`=0, `valid_top`=1 for exactly this cycle.
  - Next state WAIT.
- WAIT:
  - `pix_ready`=0. `img_source` is held unchanged.
  - On `ready_top`=1: `result`←`number`, `result_valid`=1 the next cycle, `frame_cnt`+=1, next state FILL.
- `ready_top` is ignored in FILL and LAUNCH; spurious pulses have no effect.
- `pix_sof` is ignored outside FILL (pixel not accepted).
- `img_source` changes only on accepted pixels in FILL. The network samples it on the `valid_top` pulse and throughout processing.

## Timing
- Reset values: state FILL, `idx`=0, `img_source`=0, `valid_top`=0, `pix_ready`=1 (combinational from state FILL), `result`=0, `result_valid`=0, `frame_cnt`=0.
- `pix_ready` and `valid_top` are decoded from the registered state, with no combinational path from inputs.
- `result_valid` and `result` are registered.
- Throughput: 1 pixel/cycle in FILL. The last pixel is accepted at cycle t; `valid_top` is high at t+1; WAIT starts at t+2.
- `ready_top` at cycle w → `result`/`result_valid` visible at w+1, FILL (`pix_ready`=1) at w+1. Minimum frame period is N_PIX+2+network latency.
- `rst` asserted in any state returns all registers to reset values on the next edge. An in-flight network computation is abandoned; its later `ready_top` arrives in FILL and is ignored.
- `frame_cnt` increments on WAIT→FILL only.

## Test plan
- Reset then stream 144 pixels, value k at pixel k, with `pix_valid` held high → `pix_ready` falls the cycle after pixel 143; one `valid_top` pulse; `img_source[8k+:8]`=k for all k.
- In WAIT, drive `ready_top`=1 with `number`=7 → next cycle `result`=7, `result_valid`=1 for one cycle, `frame_cnt`=1, `pix_ready`=1.
- Send 50 pixels, then an sof pixel 0xAA, then 143 more pixels → `valid_top` after a total of 144 post-sof pixels; slot 0 = 0xAA; exactly 194 pixels accepted.
- Random `pix_valid` gaps plus `pix_valid` held high during WAIT → no pixels accepted in WAIT or LAUNCH; `img_source` stable from LAUNCH until the `ready_top` cycle.
- `ready_top` pulse while in FILL at idx 20 → no `result_valid`; `frame_cnt` unchanged; filling continues.
- Assert `rst` during WAIT, then send a late `ready_top` → all outputs at reset values; no `result_valid`; a fresh 144-pixel frame completes normally.

Source files
------------

// File: rtl/img_loader_144.sv
// img_loader_144 -- byte-serial pixel packer feeding the 144-64-10 network.
// Collects N_PIX pixels into the flat image bus, pulses valid_top for one
// cycle, holds the image until ready_top, then latches the prediction.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pix_in/_valid/_sof: pixel stream in (sof marks pixel 0 of a new frame)
//   pix_ready         : high in FILL only (decoded from registered state)
//   img_source        : packed image, pixel k at [k*PIX_W +: PIX_W]
//   valid_top         : one-cycle start pulse to the network
//   ready_top, number : network done pulse and its prediction
//   result/_valid     : registered prediction and one-cycle update pulse
//   frame_cnt         : completed frames, wraps at 16 bits
module img_loader_144 #(
  parameter int N_PIX = 144,
  parameter int PIX_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic [N_PIX*PIX_W-1:0] img_source,
  output logic                   valid_top,
  input  logic                   ready_top,
  input  logic [31:0]            number,
  output logic [31:0]            result,
  output logic                   result_valid,
  output logic [15:0]            frame_cnt
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(N_PIX - 1);

  state_e                   state_q, state_d;
  logic [7:0]               idx_q, idx_d;
  logic [N_PIX*PIX_W-1:0]   img_q;
  logic [31:0]              result_q, result_d;
  logic                     result_valid_q, result_valid_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic                     wr_en;
  logic [7:0]               wr_slot;

  // Next-state logic. An sof pixel restarts the frame at slot 0; the
  // abandoned partial frame is simply overwritten by later pixels.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    wr_en          = 1'b0;
    wr_slot        = pix_sof ? 8'd0 : idx_q;

    case (state_q)
      S_FILL: begin
        if (pix_valid) begin
          wr_en = 1'b1;
          if (wr_slot == LAST_IDX) begin
            idx_d   = 8'd0;
            state_d = S_LAUNCH;
          end else begin
            idx_d = wr_slot + 8'd1;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ready_top) begin
          result_d       = number;
          result_valid_d = 1'b1;
          frame_cnt_d    = frame_cnt_q + 16'd1;
          state_d        = S_FILL;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FILL;
      idx_q          <= 8'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
      frame_cnt_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  // Image buffer: only accepted FILL pixels write, so the image is frozen
  // through LAUNCH and WAIT while the network reads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_q <= '0;
    end else if (wr_en) begin
      img_q[int'(wr_slot)*PIX_W +: PIX_W] <= pix_in;
    end
  end

  assign pix_ready    = (state_q == S_FILL);
  assign valid_top    = (state_q == S_LAUNCH);
  assign img_source   = img_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_img_loader_144.sv
module tb_img_loader_144;

  logic          clk;
  logic          rst;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  logic [1151:0] img_source;
  logic          valid_top;
  logic          ready_top;
  logic [31:0]   number;
  logic [31:0]   result;
  logic          result_valid;
  logic [15:0]   frame_cnt;

  int            tests;
  int            fails;
  logic [1151:0] exp_img;

  img_loader_144 #(.N_PIX(144), .PIX_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .img_source   (img_source),
    .valid_top    (valid_top),
    .ready_top    (ready_top),
    .number       (number),
    .result       (result),
    .result_valid (result_valid),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_in = 8'd0; pix_valid = 1'b0; pix_sof = 1'b0;
    ready_top = 1'b0; number = 32'd0;
    step(); step();
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL reset_pix_ready got %0b expected 1", pix_ready); end
    tests++; if (valid_top !== 1'b0) begin fails++; $display("FAIL reset_valid_top got %0b expected 0", valid_top); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %0h expected 0", result); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_result_valid got %0b expected 0", result_valid); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt got %0d expected 0", frame_cnt); end
    tests++; if (img_source !== '0) begin fails++; $display("FAIL reset_img_source not zero"); end
    rst = 1'b0;
    exp_img = '0;
  endtask

  // Full frame with pix_valid held high; pixel k carries value k.
  task automatic test_fill();
    int pulses;
    int bad;
    pix_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 144; k++) begin
      pix_in = 8'(k);
      pix_sof = (k == 0);
      if (pix_ready !== 1'b1) bad++;
      exp_img[k*8 +: 8] = 8'(k);
      step();
    end
    pix_sof = 1'b0;
    pix_in = 8'hEE;
    tests++; if (bad != 0) begin fails++; $display("FAIL fill_ready_during_fill got %0d stalls expected 0", bad); end
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_after_last got %0b expected 0", pix_ready); end
    tests++; if (valid_top !== 1'b1) begin fails++; $display("FAIL fill_launch got %0b expected 1", valid_top); end
    step();
    tests++; if (valid_top !== 1'b0) begin fails++; $display("FAIL fill_launch_one_cycle got %0b expected 0", valid_top); end
    tests++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL fill_ready_wait got %0b expected 0", pix_ready); end
    bad = 0;
    for (int k = 0; k < 144; k++) if (img_source[k*8 +: 8] !== 8'(k)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL fill_img got %0d wrong bytes expected 0", bad); end
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (valid_top === 1'b1) pulses++;
      step();
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL fill_extra_pulses got %0d expected 0", pulses); end
  endtask

  task automatic test_result();
    pix_valid = 1'b0;
    ready_top = 1'b1;
    number = 32'd7;
    step();
    ready_top = 1'b0;
    number = 32'hDEAD_BEEF;
    tests++; if (result !== 32'd7) begin fails++; $display("FAIL result_value got %0h expected 7", result); end
    tests++; if (result_valid !== 1'b1) begin fails++; $display("FAIL result_valid got %0b expected 1", result_valid); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL result_frame_cnt got %0d expected 1", frame_cnt); end
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL result_ready got %0b expected 1", pix_ready); end
    step();
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL result_valid_pulse got %0b expected 0", result_valid); end
    tests++; if (result !== 32'd7) begin fails++; $display("FAIL result_hold got %0h expected 7", result); end
  endtask

  // 50 pixels, then an sof pixel restarts the frame: 194 accepted in total.
  task automatic test_sof();
    int accepted;
    int bad;
    accepted = 0;
    bad = 0;
    pix_valid = 1'b1;
    for (int i = 0; i < 194; i++) begin
      if (i < 50) begin
        pix_in = 8'(200 + i); pix_sof = 1'b0;
      end else if (i == 50) begin
        pix_in = 8'hAA; pix_sof = 1'b1;
      end else begin
        pix_in = 8'((i - 50) * 7 + 1); pix_sof = 1'b0;
        exp_img[(i-50)*8 +: 8] = 8'((i - 50) * 7 + 1);
      end
      if (pix_ready === 1'b1) accepted++;
      if (valid_top !== 1'b0) bad++;
      step();
    end
    exp_img[7:0] = 8'hAA;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    tests++; if (accepted != 194) begin fails++; $display("FAIL sof_accepted got %0d expected 194", accepted); end
    tests++; if (bad != 0) begin fails++; $display("FAIL sof_early_launch got %0d expected 0", bad); end
    tests++; if (valid_top !== 1'b1) begin fails++; $display("FAIL sof_launch got %0b expected 1", valid_top); end
    tests++; if (img_source[7:0] !== 8'hAA) begin fails++; $display("FAIL sof_slot0 got %0h expected aa", img_source[7:0]); end
    tests++; if (img_source !== exp_img) begin fails++; $display("FAIL sof_img image differs from expected"); end
    step();
    ready_top = 1'b1;
    number = 32'h1234_5678;
    step();
    ready_top = 1'b0;
    tests++; if (result !== 32'h1234_5678) begin fails++; $display("FAIL sof_result got %0h expected 12345678", result); end
    tests++; if (frame_cnt !== 16'd2) begin fails++; $display("FAIL sof_frame_cnt got %0d expected 2", frame_cnt); end
  endtask

  // Gappy stream, then pix_valid (and sof) held high through LAUNCH/WAIT.
  task automatic test_gaps();
    int n;
    int cyc;
    int bad;
    n = 0;
    cyc = 0;
    bad = 0;
    while (n < 144 && cyc < 1000) begin
      if (cyc % 3 == 1 || cyc % 7 == 5) begin
        pix_valid = 1'b0;
        pix_in = 8'h55;
        pix_sof = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_in = 8'(n * 3 + 5);
        pix_sof = (n == 0);
        if (pix_ready !== 1'b1) bad++;
        exp_img[n*8 +: 8] = 8'(n * 3 + 5);
        n++;
      end
      step();
      cyc++;
    end
    tests++; if (n != 144) begin fails++; $display("FAIL gaps_budget got %0d pixels expected 144", n); end
    tests++; if (bad != 0) begin fails++; $display("FAIL gaps_ready got %0d stalls expected 0", bad); end
    tests++; if (valid_top !== 1'b1) begin fails++; $display("FAIL gaps_launch got %0b expected 1", valid_top); end
    pix_valid = 1'b1;
    pix_in = 8'hFF;
    pix_sof = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (pix_ready !== 1'b0) bad++;
      if (img_source !== exp_img) bad++;
      step();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL gaps_hold got %0d violations expected 0", bad); end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    ready_top = 1'b1;
    number = 32'd42;
    tests++; if (img_source !== exp_img) begin fails++; $display("FAIL gaps_img_at_ready image changed"); end
    step();
    ready_top = 1'b0;
    tests++; if (result !== 32'd42) begin fails++; $display("FAIL gaps_result got %0h expected 2a", result); end
    tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL gaps_frame_cnt got %0d expected 3", frame_cnt); end
  endtask

  // ready_top while filling at idx 20 must be ignored.
  task automatic test_spurious_ready();
    int bad;
    pix_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pix_in = 8'(k + 100); pix_sof = (k == 0);
      step();
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    ready_top = 1'b1;
    number = 32'd99;
    step();
    ready_top = 1'b0;
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL spur_result_valid got %0b expected 0", result_valid); end
    tests++; if (frame_cnt !== 16'd3) begin fails++; $display("FAIL spur_frame_cnt got %0d expected 3", frame_cnt); end
    tests++; if (result !== 32'd42) begin fails++; $display("FAIL spur_result got %0h expected 2a", result); end
    bad = 0;
    pix_valid = 1'b1;
    for (int k = 20; k < 144; k++) begin
      pix_in = 8'(k + 100);
      if (pix_ready !== 1'b1 || valid_top !== 1'b0) bad++;
      step();
    end
    pix_valid = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL spur_continue got %0d stalls expected 0", bad); end
    tests++; if (valid_top !== 1'b1) begin fails++; $display("FAIL spur_launch got %0b expected 1", valid_top); end
    tests++; if (img_source[20*8 +: 8] !== 8'd120) begin fails++; $display("FAIL spur_slot20 got %0d expected 120", img_source[20*8 +: 8]); end
    step();
    ready_top = 1'b1;
    number = 32'd5;
    step();
    ready_top = 1'b0;
    tests++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL spur_frame_cnt_after got %0d expected 4", frame_cnt); end
  endtask

  // Reset during WAIT abandons the frame; the late ready_top is ignored.
  task automatic test_rst_wait();
    pix_valid = 1'b1;
    for (int k = 0; k < 144; k++) begin
      pix_in = 8'(k ^ 8'h3C); pix_sof = (k == 0);
      step();
    end
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    step();
    tests++; if (pix_ready !== 1'b0 || valid_top !== 1'b0) begin fails++; $display("FAIL rst_in_wait got ready=%0b valid=%0b expected 0 0", pix_ready, valid_top); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (pix_ready !== 1'b1) begin fails++; $display("FAIL rst_pix_ready got %0b expected 1", pix_ready); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_frame_cnt got %0d expected 0", frame_cnt); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL rst_result got %0h expected 0", result); end
    tests++; if (img_source !== '0) begin fails++; $display("FAIL rst_img image not cleared"); end
    ready_top = 1'b1;
    number = 32'd77;
    step();
    ready_top = 1'b0;
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL rst_late_ready got %0b expected 0", result_valid); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL rst_late_result got %0h expected 0", result); end
    pix_valid = 1'b1;
    for (int k = 0; k < 144; k++) begin
      pix_in = 8'(255 - k); pix_sof = 1'b0;
      step();
    end
    pix_valid = 1'b0;
    tests++; if (valid_top !== 1'b1) begin fails++; $display("FAIL rst_fresh_launch got %0b expected 1", valid_top); end
    tests++; if (img_source[143*8 +: 8] !== 8'd112) begin fails++; $display("FAIL rst_fresh_slot143 got %0d expected 112", img_source[143*8 +: 8]); end
    step();
    ready_top = 1'b1;
    number = 32'd9;
    step();
    ready_top = 1'b0;
    tests++; if (result !== 32'd9 || result_valid !== 1'b1) begin fails++; $display("FAIL rst_fresh_result got %0h/%0b expected 9/1", result, result_valid); end
    tests++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL rst_fresh_frame_cnt got %0d expected 1", frame_cnt); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill();
    test_result();
    test_sof();
    test_gaps();
    test_spurious_ready();
    test_rst_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
